// File: rtl/apb3_pixfifo_pkg.sv
// Shared register map, field positions and APB FSM state encoding for the
// APB3 pixel FIFO responder.
package apb3_pixfifo_pkg;

    localparam logic [7:0] REG_DATA_OFF   = 8'h00;
    localparam logic [7:0] REG_STATUS_OFF = 8'h04;
    localparam logic [7:0] REG_CTRL_OFF   = 8'h08;
    localparam logic [7:0] REG_THRESH_OFF = 8'h0C;

    localparam int unsigned STATUS_EMPTY_BIT = 32'd0;
    localparam int unsigned STATUS_FULL_BIT  = 32'd1;
    localparam int unsigned STATUS_OVF_BIT   = 32'd2;
    localparam int unsigned STATUS_LEVEL_LSB = 32'd8;

    localparam int unsigned CTRL_EN_BIT    = 32'd0;
    localparam int unsigned CTRL_IRQEN_BIT = 32'd1;
    localparam int unsigned CTRL_FLUSH_BIT = 32'd2;

    typedef enum logic [1:0] {
        FSM_IDLE   = 2'd0,
        FSM_SETUP  = 2'd1,
        FSM_WAIT   = 2'd2,
        FSM_ACCESS = 2'd3
    } apb_state_e;

endpackage

// File: rtl/pixfifo_mem.sv
// Synchronous circular FIFO with a registered read port; a push into a full
// FIFO is accepted only when a pop retires the head in the same cycle.
module pixfifo_mem #(
    parameter int unsigned DEPTH  = 16,
    parameter int unsigned DATA_W = 32
) (
    input  logic                         clk_i,
    input  logic                         rst_n_i,
    input  logic                         push_i,
    input  logic                         pop_i,
    input  logic                         flush_i,
    input  logic [DATA_W-1:0]            wdata_i,
    output logic [DATA_W-1:0]            rdata_o,
    output logic [$clog2(DEPTH+1)-1:0]   level_o,
    output logic                         empty_o,
    output logic                         full_o
);
    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned LVL_W = $clog2(DEPTH + 1);

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [LVL_W-1:0]  level_q, level_d;
    logic [DATA_W-1:0] rdata_q;
    logic              push_ok_s, pop_ok_s;

    assign empty_o   = (level_q == LVL_W'(0));
    assign full_o    = (level_q == LVL_W'(DEPTH));
    assign pop_ok_s  = pop_i & ~empty_o;
    assign push_ok_s = push_i & (~full_o | pop_ok_s);
    assign rdata_o   = rdata_q;
    assign level_o   = level_q;

    // Pointer and occupancy next-state; flush overrides any push or pop.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        if (flush_i) begin
            wr_ptr_d = PTR_W'(0);
            rd_ptr_d = PTR_W'(0);
            level_d  = LVL_W'(0);
        end else begin
            if (push_ok_s) wr_ptr_d = wr_ptr_q + PTR_W'(1);
            else           wr_ptr_d = wr_ptr_q;
            if (pop_ok_s)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
            else           rd_ptr_d = rd_ptr_q;
            if (push_ok_s && !pop_ok_s)      level_d = level_q + LVL_W'(1);
            else if (pop_ok_s && !push_ok_s) level_d = level_q - LVL_W'(1);
            else                             level_d = level_q;
        end
    end

    // Pointer, level and registered head-word state.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            wr_ptr_q <= PTR_W'(0);
            rd_ptr_q <= PTR_W'(0);
            level_q  <= LVL_W'(0);
            rdata_q  <= DATA_W'(0);
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
            rdata_q  <= mem_q[rd_ptr_q];
        end
    end

    // Storage array, written only by accepted pushes.
    always_ff @(posedge clk_i) begin
        if (push_ok_s && !flush_i) begin
            mem_q[wr_ptr_q] <= wdata_i;
        end
    end

endmodule

// File: rtl/apb3_pixel_fifo_slave.sv
// APB3 completer exposing a camera pixel FIFO: DATA pops with one wait state,
// STATUS/CTRL/THRESH registers, error responses and a level/overflow irq.
import apb3_pixfifo_pkg::*;

module apb3_pixel_fifo_slave #(
    parameter int unsigned ADDR_W     = 8,
    parameter int unsigned FIFO_DEPTH = 16,
    parameter int unsigned TH_RESET   = 8
) (
    input  logic              PCLK,
    input  logic              PRESETN,
    input  logic              PSEL,
    input  logic              PENABLE,
    input  logic              PWRITE,
    input  logic [ADDR_W-1:0] PADDR,
    input  logic [31:0]       PWDATA,
    output logic [31:0]       PRDATA,
    output logic              PREADY,
    output logic              PSLVERR,
    input  logic              pix_valid,
    input  logic [31:0]       pix_data,
    output logic              irq
);
    localparam int unsigned AW    = ADDR_W - 2;
    localparam int unsigned LVL_W = $clog2(FIFO_DEPTH + 1);

    apb_state_e        state_q, state_d, cur_state_s;
    logic [AW-1:0]     addr_word_s, addr_word_q, addr_word_d;
    logic              hit_data_s, hit_status_s, hit_ctrl_s, hit_thresh_s;
    logic              err_s, data_rd_s;
    logic [31:0]       reg_rdata_s, prdata_q, prdata_d;
    logic              pready_q, pready_d, pslverr_q, pslverr_d;
    logic              pop_pend_q, pop_pend_d, wr_ok_q, wr_ok_d;
    logic              en_q, en_d, irq_en_q, irq_en_d, flush_q, flush_d;
    logic              ovf_q, ovf_d, irq_q, irq_d;
    logic [7:0]        thresh_q, thresh_d;
    logic              access_done_s, pop_s, push_s;
    logic              wr_ctrl_s, wr_thresh_s, wr_status_s;
    logic [31:0]       mem_rdata_s;
    logic [LVL_W-1:0]  level_s;
    logic [7:0]        level8_s;
    logic              empty_s, full_s;
    logic              unused_s;

    assign unused_s     = ^{PADDR[1:0], PWDATA[31:8]};
    assign level8_s     = 8'(level_s);
    assign addr_word_s  = PADDR[ADDR_W-1:2];
    assign hit_data_s   = (addr_word_s == AW'(REG_DATA_OFF   >> 2'd2));
    assign hit_status_s = (addr_word_s == AW'(REG_STATUS_OFF >> 2'd2));
    assign hit_ctrl_s   = (addr_word_s == AW'(REG_CTRL_OFF   >> 2'd2));
    assign hit_thresh_s = (addr_word_s == AW'(REG_THRESH_OFF >> 2'd2));
    assign err_s        = ~(hit_data_s | hit_status_s | hit_ctrl_s | hit_thresh_s)
                        | (hit_data_s & (PWRITE | empty_s));
    assign data_rd_s    = hit_data_s & ~PWRITE & ~empty_s;

    pixfifo_mem #(.DEPTH(FIFO_DEPTH), .DATA_W(32)) u_mem (
        .clk_i   (PCLK),
        .rst_n_i (PRESETN),
        .push_i  (push_s),
        .pop_i   (pop_s),
        .flush_i (flush_q),
        .wdata_i (pix_data),
        .rdata_o (mem_rdata_s),
        .level_o (level_s),
        .empty_o (empty_s),
        .full_o  (full_s)
    );

    // Register read mux, evaluated from the live bus during the setup phase.
    always_comb begin
        reg_rdata_s = 32'h0;
        if (hit_status_s) begin
            reg_rdata_s[STATUS_EMPTY_BIT]         = empty_s;
            reg_rdata_s[STATUS_FULL_BIT]          = full_s;
            reg_rdata_s[STATUS_OVF_BIT]           = ovf_q;
            reg_rdata_s[STATUS_LEVEL_LSB +: 8]    = level8_s;
        end else if (hit_ctrl_s) begin
            reg_rdata_s[CTRL_EN_BIT]    = en_q;
            reg_rdata_s[CTRL_IRQEN_BIT] = irq_en_q;
        end else if (hit_thresh_s) begin
            reg_rdata_s[7:0] = thresh_q;
        end else begin
            reg_rdata_s = 32'h0;
        end
    end

    // The setup phase is recognised from the bus while the FSM rests, so the
    // wait state of a DATA read lands on the first PENABLE cycle.
    always_comb begin
        if (PSEL && !PENABLE && (state_q == FSM_IDLE || state_q == FSM_ACCESS)) begin
            cur_state_s = FSM_SETUP;
        end else begin
            cur_state_s = state_q;
        end
    end

    // APB FSM next state and registered response.
    always_comb begin
        state_d     = FSM_IDLE;
        prdata_d    = 32'h0;
        pslverr_d   = 1'b0;
        addr_word_d = addr_word_q;
        pop_pend_d  = pop_pend_q;
        wr_ok_d     = wr_ok_q;
        case (cur_state_s)
            FSM_SETUP: begin
                state_d     = data_rd_s ? FSM_WAIT : FSM_ACCESS;
                addr_word_d = addr_word_s;
                pop_pend_d  = data_rd_s;
                wr_ok_d     = PWRITE & ~err_s;
                pslverr_d   = err_s;
                if (!PWRITE && !err_s && !hit_data_s) prdata_d = reg_rdata_s;
                else                                  prdata_d = 32'h0;
            end
            FSM_WAIT: begin
                state_d  = FSM_ACCESS;
                prdata_d = mem_rdata_s;
            end
            FSM_ACCESS: state_d = FSM_IDLE;
            FSM_IDLE:   state_d = FSM_IDLE;
            default:    state_d = FSM_IDLE;
        endcase
        pready_d = (state_d != FSM_WAIT);
    end

    assign access_done_s = (cur_state_s == FSM_ACCESS) & PSEL & PENABLE;
    assign pop_s         = access_done_s & pop_pend_q;
    assign push_s        = pix_valid & en_q;
    assign wr_ctrl_s     = access_done_s & wr_ok_q & (addr_word_q == AW'(REG_CTRL_OFF   >> 2'd2));
    assign wr_thresh_s   = access_done_s & wr_ok_q & (addr_word_q == AW'(REG_THRESH_OFF >> 2'd2));
    assign wr_status_s   = access_done_s & wr_ok_q & (addr_word_q == AW'(REG_STATUS_OFF >> 2'd2));

    // Control registers, sticky overflow and interrupt next state.
    always_comb begin
        en_d     = en_q;
        irq_en_d = irq_en_q;
        flush_d  = 1'b0;
        thresh_d = thresh_q;
        ovf_d    = ovf_q;
        if (wr_ctrl_s) begin
            en_d     = PWDATA[CTRL_EN_BIT];
            irq_en_d = PWDATA[CTRL_IRQEN_BIT];
            flush_d  = PWDATA[CTRL_FLUSH_BIT];
        end else begin
            flush_d  = 1'b0;
        end
        if (wr_thresh_s) thresh_d = PWDATA[7:0];
        else             thresh_d = thresh_q;
        // A drop in the same cycle as a clear must stay visible.
        if (push_s && full_s && !pop_s)                 ovf_d = 1'b1;
        else if (wr_status_s && PWDATA[STATUS_OVF_BIT]) ovf_d = 1'b0;
        else                                            ovf_d = ovf_q;
        irq_d = irq_en_q & (((thresh_q != 8'h0) & (level8_s >= thresh_q)) | ovf_q);
    end

    // All state and outputs, cleared asynchronously.
    always_ff @(posedge PCLK or negedge PRESETN) begin
        if (!PRESETN) begin
            state_q     <= FSM_IDLE;
            prdata_q    <= 32'h0;
            pready_q    <= 1'b1;
            pslverr_q   <= 1'b0;
            addr_word_q <= AW'(0);
            pop_pend_q  <= 1'b0;
            wr_ok_q     <= 1'b0;
            en_q        <= 1'b0;
            irq_en_q    <= 1'b0;
            flush_q     <= 1'b0;
            thresh_q    <= 8'(TH_RESET);
            ovf_q       <= 1'b0;
            irq_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            prdata_q    <= prdata_d;
            pready_q    <= pready_d;
            pslverr_q   <= pslverr_d;
            addr_word_q <= addr_word_d;
            pop_pend_q  <= pop_pend_d;
            wr_ok_q     <= wr_ok_d;
            en_q        <= en_d;
            irq_en_q    <= irq_en_d;
            flush_q     <= flush_d;
            thresh_q    <= thresh_d;
            ovf_q       <= ovf_d;
            irq_q       <= irq_d;
        end
    end

    assign PRDATA  = prdata_q;
    assign PREADY  = pready_q;
    assign PSLVERR = pslverr_q;
    assign irq     = irq_q;

endmodule

// File: tb/tb_apb3_pixel_fifo_slave.sv
// Directed bench for apb3_pixel_fifo_slave with hand-computed expectations.
module tb_apb3_pixel_fifo_slave;
    logic        clk = 1'b0;
    logic        PRESETN, PSEL, PENABLE, PWRITE;
    logic [7:0]  PADDR;
    logic [31:0] PWDATA, PRDATA, pix_data;
    logic        PREADY, PSLVERR, pix_valid, irq;
    int          checks   = 0;
    int          failures = 0;

    always #5 clk = ~clk;

    apb3_pixel_fifo_slave #(.ADDR_W(8), .FIFO_DEPTH(16), .TH_RESET(8)) dut (
        .PCLK(clk), .PRESETN(PRESETN), .PSEL(PSEL), .PENABLE(PENABLE),
        .PWRITE(PWRITE), .PADDR(PADDR), .PWDATA(PWDATA), .PRDATA(PRDATA),
        .PREADY(PREADY), .PSLVERR(PSLVERR), .pix_valid(pix_valid),
        .pix_data(pix_data), .irq(irq)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    // One APB transfer; optionally strobes a pixel during the completion cycle.
    task automatic apb_chk(input string tag, input logic wr, input logic [7:0] addr,
                           input logic [31:0] wd, input logic [31:0] exp_rd,
                           input logic exp_err, input int exp_waits,
                           input logic push_done = 1'b0, input logic [31:0] pd = 32'h0);
        int waits;
        @(posedge clk); #1;
        PSEL = 1'b1; PENABLE = 1'b0; PWRITE = wr; PADDR = addr; PWDATA = wd;
        @(posedge clk); #1;
        PENABLE = 1'b1;
        waits = 0;
        while (!PREADY && waits < 8) begin
            @(posedge clk); #1;
            waits++;
        end
        if (push_done) begin
            pix_valid = 1'b1; pix_data = pd;
        end
        chk({tag, "_rdata"}, PRDATA, exp_rd);
        chk({tag, "_slverr"}, {31'd0, PSLVERR}, {31'd0, exp_err});
        chk({tag, "_waits"}, 32'(waits), 32'(exp_waits));
        @(posedge clk); #1;
        PSEL = 1'b0; PENABLE = 1'b0; pix_valid = 1'b0;
    endtask

    task automatic burst(input int n, input logic [31:0] base);
        @(posedge clk); #1;
        for (int i = 0; i < n; i++) begin
            pix_valid = 1'b1; pix_data = base + 32'(i);
            @(posedge clk); #1;
        end
        pix_valid = 1'b0;
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        PRESETN = 1'b0; PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0;
        PADDR = 8'h0; PWDATA = 32'h0; pix_valid = 1'b0; pix_data = 32'h0;
        repeat (3) @(posedge clk); #1;
        chk("rst_pready",  {31'd0, PREADY},  32'd1);
        chk("rst_prdata",  PRDATA,           32'h0);
        chk("rst_pslverr", {31'd0, PSLVERR}, 32'd0);
        chk("rst_irq",     {31'd0, irq},     32'd0);
        PRESETN = 1'b1;

        apb_chk("status_rst", 1'b0, 8'h04, 32'h0, 32'h0000_0001, 1'b0, 0);
        apb_chk("thresh_rst", 1'b0, 8'h0C, 32'h0, 32'h0000_0008, 1'b0, 0);

        apb_chk("ctrl_en", 1'b1, 8'h08, 32'h1, 32'h0, 1'b0, 0);
        burst(3, 32'hA0);
        apb_chk("status_l3", 1'b0, 8'h04, 32'h0, 32'h0000_0300, 1'b0, 0);
        apb_chk("pop_a0", 1'b0, 8'h00, 32'h0, 32'hA0, 1'b0, 1);
        apb_chk("pop_a1", 1'b0, 8'h00, 32'h0, 32'hA1, 1'b0, 1);
        apb_chk("pop_a2", 1'b0, 8'h00, 32'h0, 32'hA2, 1'b0, 1);
        apb_chk("status_drained", 1'b0, 8'h04, 32'h0, 32'h0000_0001, 1'b0, 0);

        apb_chk("pop_empty", 1'b0, 8'h00, 32'h0, 32'h0, 1'b1, 0);
        apb_chk("unmapped", 1'b0, 8'h20, 32'h0, 32'h0, 1'b1, 0);
        burst(1, 32'hB0);
        apb_chk("wr_data", 1'b1, 8'h00, 32'h55, 32'h0, 1'b1, 0);
        apb_chk("status_l1", 1'b0, 8'h04, 32'h0, 32'h0000_0100, 1'b0, 0);
        apb_chk("pop_b0", 1'b0, 8'h00, 32'h0, 32'hB0, 1'b0, 1);
        apb_chk("ctrl_rd", 1'b0, 8'h08, 32'h0, 32'h1, 1'b0, 0);

        burst(17, 32'hC00);
        apb_chk("status_ovf", 1'b0, 8'h04, 32'h0, 32'h0000_1006, 1'b0, 0);
        apb_chk("w1c_ovf", 1'b1, 8'h04, 32'h4, 32'h0, 1'b0, 0);
        apb_chk("status_w1c", 1'b0, 8'h04, 32'h0, 32'h0000_1002, 1'b0, 0);
        apb_chk("pop_push_full", 1'b0, 8'h00, 32'h0, 32'hC00, 1'b0, 1, 1'b1, 32'hD00D);
        apb_chk("status_full_keep", 1'b0, 8'h04, 32'h0, 32'h0000_1002, 1'b0, 0);
        for (int i = 1; i < 16; i++) begin
            apb_chk($sformatf("drain_%0d", i), 1'b0, 8'h00, 32'h0, 32'hC00 + 32'(i), 1'b0, 1);
        end
        apb_chk("drain_last", 1'b0, 8'h00, 32'h0, 32'hD00D, 1'b0, 1);
        apb_chk("status_empty2", 1'b0, 8'h04, 32'h0, 32'h0000_0001, 1'b0, 0);

        burst(2, 32'h90);
        apb_chk("flush_wr", 1'b1, 8'h08, 32'h5, 32'h0, 1'b0, 0);
        apb_chk("status_flushed", 1'b0, 8'h04, 32'h0, 32'h0000_0001, 1'b0, 0);
        apb_chk("ctrl_noflush", 1'b0, 8'h08, 32'h0, 32'h1, 1'b0, 0);

        apb_chk("thresh_wr", 1'b1, 8'h0C, 32'h4, 32'h0, 1'b0, 0);
        apb_chk("ctrl_irqen", 1'b1, 8'h08, 32'h3, 32'h0, 1'b0, 0);
        burst(3, 32'hE0);
        chk("irq_l3", {31'd0, irq}, 32'd0);
        burst(1, 32'hE3);
        chk("irq_l4_same", {31'd0, irq}, 32'd0);
        @(posedge clk); #1;
        chk("irq_l4_rise", {31'd0, irq}, 32'd1);
        apb_chk("pop_e0", 1'b0, 8'h00, 32'h0, 32'hE0, 1'b0, 1);
        chk("irq_pop_hold", {31'd0, irq}, 32'd1);
        @(posedge clk); #1;
        chk("irq_pop_fall", {31'd0, irq}, 32'd0);

        apb_chk("thresh_zero", 1'b1, 8'h0C, 32'h0, 32'h0, 1'b0, 0);
        burst(14, 32'hF00);
        apb_chk("status_ovf2", 1'b0, 8'h04, 32'h0, 32'h0000_1006, 1'b0, 0);
        chk("irq_ovf", {31'd0, irq}, 32'd1);
        repeat (5) @(posedge clk); #1;
        chk("irq_ovf_sticky", {31'd0, irq}, 32'd1);
        apb_chk("w1c_ovf2", 1'b1, 8'h04, 32'h4, 32'h0, 1'b0, 0);
        chk("irq_w1c_hold", {31'd0, irq}, 32'd1);
        @(posedge clk); #1;
        chk("irq_w1c_fall", {31'd0, irq}, 32'd0);
        apb_chk("flush2_wr", 1'b1, 8'h08, 32'h7, 32'h0, 1'b0, 0);
        apb_chk("status_flushed2", 1'b0, 8'h04, 32'h0, 32'h0000_0001, 1'b0, 0);
        apb_chk("ctrl_rd2", 1'b0, 8'h08, 32'h0, 32'h3, 1'b0, 0);

        burst(1, 32'h77);
        @(posedge clk); #1;
        PSEL = 1'b1; PENABLE = 1'b0; PWRITE = 1'b0; PADDR = 8'h00;
        @(posedge clk); #1;
        PENABLE = 1'b1;
        chk("wait_pready", {31'd0, PREADY}, 32'd0);
        PRESETN = 1'b0;
        #1;
        chk("rst_wait_pready", {31'd0, PREADY}, 32'd1);
        chk("rst_wait_prdata", PRDATA, 32'h0);
        @(posedge clk); #1;
        PSEL = 1'b0; PENABLE = 1'b0;
        @(posedge clk); #1;
        PRESETN = 1'b1;
        apb_chk("status_after_rst", 1'b0, 8'h04, 32'h0, 32'h0000_0001, 1'b0, 0);
        apb_chk("ctrl_after_rst", 1'b0, 8'h08, 32'h0, 32'h0, 1'b0, 0);
        apb_chk("thresh_after_rst", 1'b0, 8'h0C, 32'h0, 32'h8, 1'b0, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
